// File: rtl/ps2_kbd_if.sv
// Sequencer instruction bus as seen by the keyboard peripheral.
// The sequencer (master) issues instructions; the peripheral (slave) returns
// the data register and status flags.
interface ps2_kbd_if;
  logic [11:0] inst;
  logic        inst_en;
  logic [7:0]  data;
  logic        ready;
  logic        overflow;
  logic        error;

  modport master (output inst, inst_en, input data, ready, overflow, error);
  modport slave  (input inst, inst_en, output data, ready, overflow, error);
endinterface

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 wires, deserialises
// device-to-host frames and queues accepted scancodes in a small FIFO that
// the sequencer drains with POP and flushes with CLR.
module ps2_kbd #(
  parameter int FIFO_LOG2 = 2,
  parameter int TIMEOUT   = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_kbd_if.slave   bus
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  // Synchroniser and edge-detect stages
  logic ck_s1_q, ck_s2_q, ck_prev_q, dt_s1_q, dt_s2_q;
  logic ck_s1_d, ck_s2_d, ck_prev_d, dt_s1_d, dt_s2_d;

  // Receiver state
  rx_state_e      state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  // FIFO and sequencer-visible registers
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]         data_q, data_d;
  logic               ovf_q, ovf_d, err_q, err_d;

  logic fall, bit_in, rx_push, rx_err;
  logic empty, full, op_pop, op_clr, do_pop;
  logic unused_imm;

  assign unused_imm = ^bus.inst[7:0];

  // Two-flop synchronisers plus a delayed copy of the clock for edge detection
  always_comb begin
    ck_s1_d   = ps2_clk;
    ck_s2_d   = ck_s1_q;
    ck_prev_d = ck_s2_q;
    dt_s1_d   = ps2_data;
    dt_s2_d   = dt_s1_q;
  end

  assign fall   = ck_prev_q & ~ck_s2_q;
  assign bit_in = dt_s2_q;

  // Frame receiver: start / 8 data bits LSB first / odd parity / stop
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = '0;
    rx_push   = 1'b0;
    rx_err    = 1'b0;
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        rx_err  = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            rx_err = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          if (bit_in && (^{shift_q, par_q})) rx_push = 1'b1;
          else                               rx_err  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]) &&
                  (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]);
  assign op_pop = bus.inst_en && (bus.inst[11:8] == 4'h1);
  assign op_clr = bus.inst_en && (bus.inst[11:8] == 4'h2);
  assign do_pop = op_pop && !empty;

  // FIFO update; a same-cycle pop frees the slot the push needs, and CLR
  // overrides both the push and any receiver error raised this cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (op_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      data_d   = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
    end else begin
      if (do_pop) begin
        data_d   = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (rx_push) begin
        if (!full || do_pop) begin
          mem_d[wr_ptr_q[FIFO_LOG2-1:0]] = shift_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (rx_err) err_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_s1_q   <= 1'b1;
      ck_s2_q   <= 1'b1;
      ck_prev_q <= 1'b1;
      dt_s1_q   <= 1'b1;
      dt_s2_q   <= 1'b1;
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ck_s1_q   <= ck_s1_d;
      ck_s2_q   <= ck_s2_d;
      ck_prev_q <= ck_prev_d;
      dt_s1_q   <= dt_s1_d;
      dt_s2_q   <= dt_s2_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.ready    = ~empty;
  assign bus.overflow = ovf_q;
  assign bus.error    = err_q;

endmodule
